// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types, widths and byte-count clamp for the I2C master arbiter
package i2c_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int NB_W   = 3;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        COMPLETE
    } arb_state_t;

    // A zero count still moves one byte; the master core cannot do more than four.
    function automatic logic [NB_W-1:0] clamp_nbytes(input logic [NB_W-1:0] n);
        logic [NB_W-1:0] r;
        if (n == '0) begin
            r = NB_W'(1);
        end else if (n > NB_W'(4)) begin
            r = NB_W'(4);
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin priority search starting at ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    // Walk the requesters from ptr upward with wrap-around; first set bit wins.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!valid && req[j]) begin
                valid = 1'b1;
                index = IDX_W'(j);
            end
        end
    end

    assign grant = valid ? (NUM_REQ'(1) << index) : '0;

endmodule

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin sharing of one I2C master core with watchdog and idle gap
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int GAP_CYCLES     = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*NB_W-1:0]   req_nbytes,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ack_error,
    output logic                      timeout,
    output logic                      busy,
    output logic                      m_start,
    output logic [ADDR_W-1:0]         m_addr,
    output logic                      m_rw,
    output logic [NB_W-1:0]           m_nbytes,
    output logic [DATA_W-1:0]         m_wdata,
    output logic                      m_abort,
    input  logic                      m_done,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_ack_error
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 2);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win;
    logic [GAP_W-1:0]   gap_cnt;
    logic [WDOG_W-1:0]  wdog;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_index;
    logic               arb_valid;
    logic               expiry;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .index (arb_index),
        .valid (arb_valid)
    );

    // The abort must see a same-cycle m_done, so it is decoded from the current
    // state rather than registered: a completion on the expiry cycle suppresses it.
    assign expiry  = (state == WAIT_DONE) && (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign m_abort = expiry && !m_done;
    assign busy    = (state != IDLE);

    // Transaction sequencer: arbitrate, issue, wait with watchdog, report, then enforce the idle gap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            win       <= '0;
            gap_cnt   <= '0;
            wdog      <= '0;
            grant     <= '0;
            done      <= '0;
            rdata     <= '0;
            ack_error <= 1'b0;
            timeout   <= 1'b0;
            m_start   <= 1'b0;
            m_addr    <= '0;
            m_rw      <= 1'b0;
            m_nbytes  <= '0;
            m_wdata   <= '0;
        end else begin
            done    <= '0;
            m_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end else if (arb_valid) begin
                        win      <= arb_index;
                        grant    <= arb_grant;
                        m_start  <= 1'b1;
                        m_addr   <= req_addr[ADDR_W*arb_index +: ADDR_W];
                        m_rw     <= req_rw[arb_index];
                        m_nbytes <= clamp_nbytes(req_nbytes[NB_W*arb_index +: NB_W]);
                        m_wdata  <= req_wdata[DATA_W*arb_index +: DATA_W];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog  <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    wdog <= wdog + WDOG_W'(1);
                    if (m_done) begin
                        done      <= grant;
                        rdata     <= m_rw ? m_rdata : '0;
                        ack_error <= m_ack_error;
                        timeout   <= 1'b0;
                        state     <= COMPLETE;
                    end else if (expiry) begin
                        done      <= grant;
                        rdata     <= '0;
                        ack_error <= 1'b1;
                        timeout   <= 1'b1;
                        state     <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    grant     <= '0;
                    rdata     <= '0;
                    ack_error <= 1'b0;
                    timeout   <= 1'b0;
                    m_addr    <= '0;
                    m_rw      <= 1'b0;
                    m_nbytes  <= '0;
                    m_wdata   <= '0;
                    rr_ptr    <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
                    gap_cnt   <= GAP_W'(GAP_CYCLES);
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one I2C master core among NUM_REQ fabric requesters, e.g. the myocontrol angle/sense logic and HPS-side pollers that each need the same physical i2c_N conduit.
- Grants requesters round-robin and issues one transaction to the master's command interface.
- Waits for completion, with a watchdog timeout, then returns read data and error status to the winning requester.
- Enforces a minimum bus-idle gap between consecutive transactions.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 50000, maximum clock cycles from m_start to m_done before abort (1 ms at 50 MHz).
- GAP_CYCLES, 8, minimum idle clock cycles between a completion and the next m_start.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until the matching done pulse.
- req_addr  in  NUM_REQ*7  7-bit slave address per requester, flattened; requester i at [7i+6:7i].
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_nbytes  in  NUM_REQ*3  byte count 1..4 per requester; 0 is treated as 1, values >4 are clamped to 4.
- req_wdata  in  NUM_REQ*32  write data per requester, LSB byte sent first.
- grant  out  NUM_REQ  one-hot, high from ISSUE through COMPLETE inclusive.
- done  out  NUM_REQ  one-cycle completion pulse to the winner.
- rdata  out  32  read data; valid only in the done cycle.
- ack_error  out  1  NACK or timeout; valid only in the done cycle.
- timeout  out  1  watchdog expiry; valid only in the done cycle.
- busy  out  1  high in any state other than IDLE.
- m_start  out  1  one-cycle command strobe to the master.
- m_addr  out  7  slave address to the master.
- m_rw  out  1  direction to the master.
- m_nbytes  out  3  byte count to the master.
- m_wdata  out  32  write data to the master.
- m_abort  out  1  one-cycle abort strobe to the master on timeout.
- m_done  in  1  master completion pulse.
- m_rdata  in  32  master read data, valid with m_done.
- m_ack_error  in  1  master NACK flag, valid with m_done.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr=0; gap_cnt=0; wdog=0.
- IDLE:
  - If gap_cnt!=0, decrement it and issue no grant.
  - Otherwise, if req!=0, pick the first set bit searching from rr_ptr upward with wrap-around.
  - Latch the winner index and its addr, rw, clamped nbytes and wdata into registers, then go to ISSUE.
- ISSUE (one cycle):
  - grant[win]=1, m_start=1.
  - m_* outputs driven from the latched registers and held constant until leaving COMPLETE.
  - wdog cleared; go to WAIT_DONE.
- WAIT_DONE:
  - wdog increments each cycle.
  - On m_done: capture m_rdata and m_ack_error, go to COMPLETE.
  - Else, when wdog==TIMEOUT_CYCLES-1: m_abort=1 that cycle, set timeout_flag, go to COMPLETE.
  - m_done in the same cycle as expiry: m_done wins and no abort is issued.
- COMPLETE (one cycle):
  - done[win]=1 and rdata, ack_error, timeout driven.
  - On timeout, ack_error=1 and rdata=0.
  - If rw=0, rdata=0.
  - Set rr_ptr=(win+1) mod NUM_REQ, gap_cnt=GAP_CYCLES, then go to IDLE.
- Latency: req seen in IDLE in cycle t gives m_start in cycle t+1. m_done in cycle d gives done in cycle d+1.
- Minimum back-to-back spacing: m_start(k+1) comes GAP_CYCLES+2 cycles after done(k).
- Requester rules:
  - A requester may drop req before its grant; it is then not served.
  - Dropping req after grant has no effect: the transaction completes and done is still pulsed.
  - Field changes after the IDLE sampling cycle are ignored.
  - A requester holding req through its done cycle is treated as a new request and re-arbitrated fairly.
- m_done outside WAIT_DONE is ignored.
- Reset asserted mid-transaction:
  - Returns to IDLE immediately; no done pulse.
  - m_abort is not asserted; the master core receives the same reset.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0.

Decomposition:
- Package i2c_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT_DONE, COMPLETE};
  - constants ADDR_W=7, NB_W=3, DATA_W=32;
  - a function that clamps nbytes.
- One natural sub-module, rr_arbiter: combinational priority search from rr_ptr. Inputs req and ptr; outputs one-hot grant and index. Parameterised by NUM_REQ, reusable for the iceboardcontrol UART sharing.

Test Plan:
- Single write: req[2]=1, addr=0x36, rw=0, nbytes=2, wdata=0x0000ABCD. Expect m_start one cycle later with m_addr=0x36, m_nbytes=2; m_done after 100 cycles → done[2] next cycle, ack_error=0, rdata=0.
- Read NACK: req[0], rw=1; master returns m_done with m_ack_error=1, m_rdata=0x12345678. Expect done[0], ack_error=1, rdata=0x12345678, timeout=0.
- Round robin: req=4'b1111 held continuously, master completes each in 10 cycles. Expect grant order 0,1,2,3,0 and m_start spacing exactly GAP_CYCLES+2 cycles after each done.
- Timeout: TIMEOUT_CYCLES=20, no m_done. Expect m_abort 20 cycles after m_start, then done with timeout=1, ack_error=1, rdata=0. Repeat with m_done arriving on the expiry cycle → no m_abort, timeout=0.
- Edge cases: nbytes=0 → m_nbytes=1; nbytes=7 → m_nbytes=4. req dropped before grant → never served. Reset during WAIT_DONE → busy=0 next cycle, no done pulse; a stray m_done afterwards is ignored.
